// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
// Groups the button/switch inputs and the conditioned event outputs of
// input_conditioner.
//   confirm_raw   : raw confirm button, asynchronous, high = pressed
//   back_raw      : raw back/cancel button, asynchronous, high = pressed
//   sw_raw[2:0]   : raw mode-select switches, asynchronous
//   mode_lock     : synchronous, high freezes mode_select
//   confirm_pulse : one-cycle pulse per accepted confirm press
//   back_pulse    : one-cycle pulse per accepted back press
//   long_press    : one-cycle pulse when confirm has been held long enough
//   mode_select   : debounced, registered switch value
//   mode_changed  : one-cycle pulse when mode_select takes a new value
// master = the side driving the raw inputs; slave = the conditioner itself.
// -----------------------------------------------------------------------------
interface input_conditioner_if;
  logic       confirm_raw;
  logic       back_raw;
  logic [2:0] sw_raw;
  logic       mode_lock;
  logic       confirm_pulse;
  logic       back_pulse;
  logic       long_press;
  logic [2:0] mode_select;
  logic       mode_changed;

  modport master (
    output confirm_raw, back_raw, sw_raw, mode_lock,
    input  confirm_pulse, back_pulse, long_press, mode_select, mode_changed
  );

  modport slave (
    input  confirm_raw, back_raw, sw_raw, mode_lock,
    output confirm_pulse, back_pulse, long_press, mode_select, mode_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronizes and debounces two push buttons (confirm, back) and a 3-bit
// mode switch group. Buttons produce one-cycle press pulses; confirm also
// produces a one-shot long_press after being held LONG_PRESS_CYCLES.
// The switch group loads mode_select once stable, unless mode_lock holds it.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : input_conditioner_if.slave (raw inputs, conditioned outputs)
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000
) (
  input logic                clk,
  input logic                rst_n,
  input_conditioner_if.slave bus
);

  // Counter value on which the next mismatching cycle completes the window.
  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  // Switch counter value marking a qualified candidate held back by mode_lock.
  localparam logic [23:0] DEB_FULL  = 24'(DEBOUNCE_CYCLES);
  localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 1);
  localparam logic [31:0] HOLD_MAX  = 32'hFFFF_FFFF;

  // Raw bit order: [0] confirm, [1] back, [4:2] switches.
  logic [4:0]       raw_s;
  logic [4:0]       meta_r;
  logic [4:0]       sync_r;
  logic [1:0]       btn_sync_s;
  logic [2:0]       sw_sync_s;

  logic [1:0]       btn_stable_r;
  logic [1:0]       btn_stable_s;
  logic [1:0][23:0] btn_cnt_r;
  logic [1:0][23:0] btn_cnt_s;
  logic [1:0]       btn_rise_s;

  logic [31:0]      hold_cnt_r;
  logic [31:0]      hold_cnt_s;
  logic             long_fire_s;

  logic [2:0]       sw_cand_r;
  logic [2:0]       sw_cand_s;
  logic [23:0]      sw_cnt_r;
  logic [23:0]      sw_cnt_s;
  logic [2:0]       mode_s;
  logic             mode_chg_s;

  logic             confirm_pulse_r;
  logic             back_pulse_r;
  logic             long_press_r;
  logic [2:0]       mode_select_r;
  logic             mode_changed_r;

  assign raw_s      = {bus.sw_raw, bus.back_raw, bus.confirm_raw};
  assign btn_sync_s = sync_r[1:0];
  assign sw_sync_s  = sync_r[4:2];

  // Two-flop synchronizer for every asynchronous input bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 5'd0;
      sync_r <= 5'd0;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Button debounce: count mismatching cycles, toggle the stable state when
  // the window completes; a rising toggle is a press.
  always_comb begin
    btn_stable_s = btn_stable_r;
    btn_cnt_s    = btn_cnt_r;
    btn_rise_s   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync_s[i] == btn_stable_r[i]) begin
        btn_cnt_s[i] = 24'd0;
      end else if (btn_cnt_r[i] == DEB_LAST) begin
        btn_stable_s[i] = ~btn_stable_r[i];
        btn_cnt_s[i]    = 24'd0;
        btn_rise_s[i]   = ~btn_stable_r[i];
      end else begin
        btn_cnt_s[i] = btn_cnt_r[i] + 24'd1;
      end
    end
  end

  // Confirm hold timer: restarts on each accepted press, counts while held,
  // saturates; long_press fires only on the step onto LONG_PRESS_CYCLES, so
  // it cannot repeat before a fresh press clears the counter.
  always_comb begin
    hold_cnt_s  = hold_cnt_r;
    long_fire_s = 1'b0;
    if (btn_rise_s[0]) begin
      hold_cnt_s = 32'd0;
    end else if (btn_stable_r[0] && (hold_cnt_r != HOLD_MAX)) begin
      hold_cnt_s  = hold_cnt_r + 32'd1;
      long_fire_s = (hold_cnt_r == LONG_LAST);
    end else begin
      hold_cnt_s = hold_cnt_r;
    end
  end

  // Switch-group debounce. A vector change captures a new candidate and
  // counts that cycle as its first stable one. A qualified candidate waiting
  // on mode_lock parks its counter at DEB_FULL until the lock drops.
  always_comb begin
    sw_cand_s  = sw_cand_r;
    sw_cnt_s   = sw_cnt_r;
    mode_s     = mode_select_r;
    mode_chg_s = 1'b0;
    if (sw_sync_s != sw_cand_r) begin
      sw_cand_s = sw_sync_s;
      sw_cnt_s  = 24'd1;
    end else if (sw_cand_r == mode_select_r) begin
      sw_cnt_s = 24'd0;
    end else if (sw_cnt_r >= DEB_LAST) begin
      if (!bus.mode_lock) begin
        mode_s     = sw_cand_r;
        mode_chg_s = 1'b1;
        sw_cnt_s   = 24'd0;
      end else begin
        sw_cnt_s = DEB_FULL;
      end
    end else begin
      sw_cnt_s = sw_cnt_r + 24'd1;
    end
  end

  // State and registered outputs. A simultaneous back press wins over confirm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable_r    <= 2'b00;
      btn_cnt_r       <= '0;
      hold_cnt_r      <= 32'd0;
      sw_cand_r       <= 3'd0;
      sw_cnt_r        <= 24'd0;
      confirm_pulse_r <= 1'b0;
      back_pulse_r    <= 1'b0;
      long_press_r    <= 1'b0;
      mode_select_r   <= 3'd0;
      mode_changed_r  <= 1'b0;
    end else begin
      btn_stable_r    <= btn_stable_s;
      btn_cnt_r       <= btn_cnt_s;
      hold_cnt_r      <= hold_cnt_s;
      sw_cand_r       <= sw_cand_s;
      sw_cnt_r        <= sw_cnt_s;
      confirm_pulse_r <= btn_rise_s[0] & ~btn_rise_s[1];
      back_pulse_r    <= btn_rise_s[1];
      long_press_r    <= long_fire_s;
      mode_select_r   <= mode_s;
      mode_changed_r  <= mode_chg_s;
    end
  end

  assign bus.confirm_pulse = confirm_pulse_r;
  assign bus.back_pulse    = back_pulse_r;
  assign bus.long_press    = long_press_r;
  assign bus.mode_select   = mode_select_r;
  assign bus.mode_changed  = mode_changed_r;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=20. The stimulus process pushes the cycle at which each
// event must appear; a negedge monitor pops and compares as events occur, and
// flags any unexpected or overdue event.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  int         q_confirm[$];
  int         q_back[$];
  int         q_long[$];
  int         q_mode[$];
  logic [2:0] q_mode_val[$];
  int         due_m;
  logic [2:0] val_m;

  input_conditioner_if ifc ();

  input_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used to time expected events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event monitor: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.confirm_pulse) begin
        if (q_confirm.size() == 0) check_val("confirm_extra", 32'd1, 32'd0);
        else check_val("confirm_time", 32'(cyc), 32'(q_confirm.pop_front()));
      end else if (q_confirm.size() > 0 && q_confirm[0] < cyc) begin
        check_val("confirm_missed", 32'd0, 32'd1);
        void'(q_confirm.pop_front());
      end

      if (ifc.back_pulse) begin
        if (q_back.size() == 0) check_val("back_extra", 32'd1, 32'd0);
        else check_val("back_time", 32'(cyc), 32'(q_back.pop_front()));
      end else if (q_back.size() > 0 && q_back[0] < cyc) begin
        check_val("back_missed", 32'd0, 32'd1);
        void'(q_back.pop_front());
      end

      if (ifc.long_press) begin
        if (q_long.size() == 0) check_val("long_extra", 32'd1, 32'd0);
        else check_val("long_time", 32'(cyc), 32'(q_long.pop_front()));
      end else if (q_long.size() > 0 && q_long[0] < cyc) begin
        check_val("long_missed", 32'd0, 32'd1);
        void'(q_long.pop_front());
      end

      if (ifc.mode_changed) begin
        if (q_mode.size() == 0) begin
          check_val("mode_extra", 32'd1, 32'd0);
        end else begin
          due_m = q_mode.pop_front();
          val_m = q_mode_val.pop_front();
          check_val("mode_time", 32'(cyc), 32'(due_m));
          check_val("mode_value", 32'(ifc.mode_select), 32'(val_m));
        end
      end else if (q_mode.size() > 0 && q_mode[0] < cyc) begin
        check_val("mode_missed", 32'd0, 32'd1);
        void'(q_mode.pop_front());
        void'(q_mode_val.pop_front());
      end
    end
  end

  initial begin
    ifc.confirm_raw = 1'b0;
    ifc.back_raw    = 1'b0;
    ifc.sw_raw      = 3'b000;
    ifc.mode_lock   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pulses", 32'({ifc.confirm_pulse, ifc.back_pulse, ifc.long_press, ifc.mode_changed}), 32'd0);
    check_val("rst_mode", 32'(ifc.mode_select), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Clean confirm press, held, then released: one pulse, none on release.
    ifc.confirm_raw = 1'b1;
    q_confirm.push_back(cyc + LAT);
    repeat (10) @(posedge clk);
    #1 ifc.confirm_raw = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Glitches shorter than the debounce window: no events.
    ifc.confirm_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1 ifc.confirm_raw = 1'b0;
    ifc.back_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1 ifc.back_raw = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Simultaneous presses: back wins; confirm held on for a long press.
    ifc.confirm_raw = 1'b1;
    ifc.back_raw    = 1'b1;
    q_back.push_back(cyc + LAT);
    q_long.push_back(cyc + LAT + LONG);
    repeat (10) @(posedge clk);
    #1 ifc.back_raw = 1'b0;
    repeat (21) @(posedge clk);
    #1 ifc.confirm_raw = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    // Unlocked switch change.
    ifc.sw_raw = 3'b101;
    q_mode.push_back(cyc + LAT);
    q_mode_val.push_back(3'b101);
    repeat (10) @(posedge clk);
    #1 check_val("mode_after_101", 32'(ifc.mode_select), 32'd5);

    // Locked switch change stays pending, loads on the edge after unlock.
    ifc.mode_lock = 1'b1;
    ifc.sw_raw    = 3'b010;
    repeat (10) @(posedge clk);
    #1 check_val("mode_locked", 32'(ifc.mode_select), 32'd5);
    ifc.mode_lock = 1'b0;
    q_mode.push_back(cyc + 1);
    q_mode_val.push_back(3'b010);
    repeat (5) @(posedge clk);
    #1 check_val("mode_after_unlock", 32'(ifc.mode_select), 32'd2);

    // Reset mid-debounce: outputs clear at once, then qualification restarts.
    ifc.sw_raw = 3'b011;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    ifc.back_raw = 1'b1;
    #1;
    check_val("rst_async_pulses", 32'({ifc.confirm_pulse, ifc.back_pulse, ifc.long_press, ifc.mode_changed}), 32'd0);
    check_val("rst_async_mode", 32'(ifc.mode_select), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q_mode.push_back(cyc + LAT);
    q_mode_val.push_back(3'b011);
    q_back.push_back(cyc + LAT);
    repeat (12) @(posedge clk);
    #1 check_val("mode_after_reset", 32'(ifc.mode_select), 32'd3);
    ifc.back_raw = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Switch bounce returning to the current mode: no mode change.
    ifc.sw_raw = 3'b110;
    repeat (2) @(posedge clk);
    #1 ifc.sw_raw = 3'b011;
    repeat (15) @(posedge clk);
    #1 check_val("mode_after_bounce", 32'(ifc.mode_select), 32'd3);

    check_val("confirm_left", 32'(q_confirm.size()), 32'd0);
    check_val("back_left", 32'(q_back.size()), 32'd0);
    check_val("long_left", 32'(q_long.size()), 32'd0);
    check_val("mode_left", 32'(q_mode.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
